// File: rtl/snn_perceptron_layer.sv
// snn_perceptron_layer: multi-neuron signed spike perceptron. One binary pixel
// vector is rate-coded against a signed weight matrix, one spike window of
// 2**WIDTH cycles per input; each neuron fires where its spike balance >= THRESHOLD.
// Latency: accept edge -> out_valid after N_IN*2**WIDTH+1 edges, independent of data.
// Backpressure: in_ready only while idle; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   in_valid/in_ready pixel vector handshake; pixels latched on accept
//   pixels            N_IN binary inputs, pixels[i] gates weight column i
//   spike_out         live per-neuron spike strobe (monitor only)
//   out_valid/ready   result handshake
//   fire              per-neuron firing decision, valid with out_valid
//   balance_out       per-neuron signed balance, neuron o at [o*BAL_W +: BAL_W]

module snn_perceptron_layer #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 7,
  parameter int N_OUT = 2,
  parameter logic [N_OUT*N_IN*(WIDTH+1)-1:0] WEIGHTS = '0,
  parameter int BAL_W = $clog2(N_IN*(2**WIDTH-1)+1)+1,
  parameter logic signed [BAL_W-1:0] THRESHOLD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        pixels,
  output logic [N_OUT-1:0]       spike_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT-1:0]       fire,
  output logic [N_OUT*BAL_W-1:0] balance_out
);

  localparam int W_ENT = WIDTH + 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_IN - 1);
  localparam logic [WIDTH-1:0] LAST_PHASE = '1;

  // EVAL is the one-cycle register stage that turns the final balance into
  // the held fire/balance result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [N_IN-1:0]         pix_q, pix_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]        phase_q, phase_d;
  logic [WIDTH-1:0]        acc_q [N_OUT];
  logic [WIDTH-1:0]        acc_d [N_OUT];
  logic signed [BAL_W-1:0] bal_q [N_OUT];
  logic signed [BAL_W-1:0] bal_d [N_OUT];
  logic [N_OUT-1:0]        fire_q, fire_d;
  logic [N_OUT*BAL_W-1:0]  balout_q, balout_d;

  logic accept;
  logic run_en;
  logic eval_en;
  logic window_end;
  logic last_input;

  logic [WIDTH-1:0] mag_tab [N_OUT][N_IN];
  logic             neg_tab [N_OUT][N_IN];
  logic [WIDTH-1:0] mag_sel [N_OUT];
  logic             neg_sel [N_OUT];
  logic [WIDTH:0]   sum     [N_OUT];
  logic [N_OUT-1:0] spike;

  // Unpack the flat weight parameter into magnitude and sign tables.
  // A negative zero simply has a zero magnitude and never spikes.
  for (genvar o = 0; o < N_OUT; o++) begin : g_wo
    for (genvar i = 0; i < N_IN; i++) begin : g_wi
      assign mag_tab[o][i] = WEIGHTS[(o*N_IN+i)*W_ENT +: WIDTH];
      assign neg_tab[o][i] = WEIGHTS[(o*N_IN+i)*W_ENT + WIDTH];
    end
  end

  assign accept     = in_valid & in_ready;
  assign window_end = (phase_q == LAST_PHASE);
  assign last_input = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (window_end && last_input) state_d = S_EVAL;
      S_EVAL: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    run_en    = 1'b0;
    eval_en   = 1'b0;
    case (state_q)
      S_IDLE: in_ready  = 1'b1;
      S_RUN:  run_en    = 1'b1;
      S_EVAL: eval_en   = 1'b1;
      S_DONE: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // ------------------------------------------------------ spike generation
  // Adding |w| into a WIDTH-bit accumulator every cycle of a 2**WIDTH-cycle
  // window wraps exactly |w| times; each wrap (carry-out) is one spike,
  // spread evenly across the window.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      mag_sel[o] = mag_tab[o][idx_q];
      neg_sel[o] = neg_tab[o][idx_q];
      sum[o]     = {1'b0, acc_q[o]} + {1'b0, mag_sel[o]};
      spike[o]   = run_en & sum[o][WIDTH] & pix_q[idx_q];
    end
  end

  assign spike_out = spike;

  // ------------------------------------------------------ datapath next state
  always_comb begin
    pix_d    = pix_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    bal_d    = bal_q;
    fire_d   = fire_q;
    balout_d = balout_q;

    if (accept) begin
      pix_d   = pixels;
      idx_d   = '0;
      phase_d = '0;
      for (int o = 0; o < N_OUT; o++) begin
        acc_d[o] = '0;
        bal_d[o] = '0;
      end
    end

    if (run_en) begin
      phase_d = phase_q + 1'b1;
      for (int o = 0; o < N_OUT; o++) begin
        acc_d[o] = window_end ? '0 : sum[o][WIDTH-1:0];
        if (spike[o]) begin
          bal_d[o] = neg_sel[o] ? (bal_q[o] - BAL_W'(1)) : (bal_q[o] + BAL_W'(1));
        end
      end
      if (window_end && !last_input) begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Balance magnitude is bounded by N_IN*(2**WIDTH-1), so no saturation.
    if (eval_en) begin
      for (int o = 0; o < N_OUT; o++) begin
        fire_d[o]                   = (bal_q[o] >= THRESHOLD);
        balout_d[o*BAL_W +: BAL_W]  = bal_q[o];
      end
    end

    // Result outputs read zero everywhere outside DONE.
    if (out_valid && out_ready) begin
      fire_d   = '0;
      balout_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q    <= '0;
      idx_q    <= '0;
      phase_q  <= '0;
      fire_q   <= '0;
      balout_q <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        acc_q[o] <= '0;
        bal_q[o] <= '0;
      end
    end else begin
      pix_q    <= pix_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      fire_q   <= fire_d;
      balout_q <= balout_d;
      for (int o = 0; o < N_OUT; o++) begin
        acc_q[o] <= acc_d[o];
        bal_q[o] <= bal_d[o];
      end
    end
  end

  assign fire        = fire_q;
  assign balance_out = balout_q;

endmodule
